// File: rtl/pixel_sync_pkg.sv
// Shared definitions for the camera pixel synchroniser: state encoding,
// pixel/coordinate width and the saturating counter helper.
package pixel_sync_pkg;

    localparam int PIX_W = 8;
    // One extra bit lets a counter reach 2**PIX_W and stick there as an overflow marker
    localparam int CNT_W = PIX_W + 1;

    typedef enum logic [1:0] {
        WAIT_SYNC  = 2'd0,
        WAIT_FRAME = 2'd1,
        IN_LINE    = 2'd2,
        LINE_GAP   = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return v[CNT_W-1] ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pixel_sync_sync_edge.sv
// Registers a sync level once and reports its rising/falling edges against
// the registered copy.
module sync_edge (
    input  logic Clk,
    input  logic nReset,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/pixel_sync.sv
// Camera frame/line tracker: emits registered pixel strobes with X/Y coordinates
// and deferred end-of-line strobes so that the last line of a frame carries Frame.
module pixel_sync
    import pixel_sync_pkg::*;
(
    input  logic             Clk,
    input  logic             nReset,
    input  logic             VSync,
    input  logic             HSync,
    input  logic             PixelValid,
    input  logic [PIX_W-1:0] PixelData,
    output logic             Pixel,
    output logic [PIX_W-1:0] PixelOut,
    output logic [PIX_W-1:0] X,
    output logic [PIX_W-1:0] Y,
    output logic             Line,
    output logic             Frame,
    output logic             Overflow
);

    logic vs_rise, vs_fall, hs_rise, hs_fall;

    sync_edge u_vs_edge (
        .Clk     (Clk),
        .nReset  (nReset),
        .level_i (VSync),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    sync_edge u_hs_edge (
        .Clk     (Clk),
        .nReset  (nReset),
        .level_i (HSync),
        .rise_o  (hs_rise),
        .fall_o  (hs_fall)
    );

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             pixel_q, pixel_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             ovf_q, ovf_d;
    logic [PIX_W-1:0] pix_out_q, pix_out_d;
    logic [PIX_W-1:0] x_q, x_d;
    logic [PIX_W-1:0] y_q, y_d;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= WAIT_SYNC;
            pending_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            pixel_q   <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pix_out_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pixel_q   <= pixel_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            pix_out_q <= pix_out_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        col_d     = col_q;
        row_d     = row_q;
        pixel_d   = 1'b0;
        line_d    = 1'b0;
        frame_d   = 1'b0;
        ovf_d     = ovf_q;
        pix_out_d = pix_out_q;
        x_d       = x_q;
        y_d       = y_q;

        case (state_q)
            WAIT_SYNC: begin
                if (!VSync) begin
                    state_d = WAIT_FRAME;
                end
            end

            WAIT_FRAME: begin
                if (vs_rise) begin
                    state_d   = LINE_GAP;
                    row_d     = '0;
                    pending_d = 1'b0;
                end
            end

            LINE_GAP: begin
                // Frame end takes priority over a coincident line start
                if (vs_fall) begin
                    line_d    = pending_q;
                    frame_d   = pending_q;
                    pending_d = 1'b0;
                    state_d   = WAIT_FRAME;
                end else if (hs_rise) begin
                    state_d = IN_LINE;
                    col_d   = '0;
                    if (pending_q) begin
                        line_d    = 1'b1;
                        pending_d = 1'b0;
                        row_d     = sat_inc(row_q);
                    end
                end
            end

            IN_LINE: begin
                if (PixelValid && HSync) begin
                    if (col_q[PIX_W] || row_q[PIX_W]) begin
                        ovf_d = 1'b1;
                    end else begin
                        pixel_d   = 1'b1;
                        pix_out_d = PixelData;
                        x_d       = col_q[PIX_W-1:0];
                        y_d       = row_q[PIX_W-1:0];
                    end
                    col_d = sat_inc(col_q);
                end
                // The line's strobe is held back until we know whether it is the last one
                if (vs_fall) begin
                    line_d    = 1'b1;
                    frame_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = WAIT_FRAME;
                end else if (hs_fall) begin
                    pending_d = 1'b1;
                    state_d   = LINE_GAP;
                end
            end

            default: state_d = WAIT_SYNC;
        endcase
    end

    assign Pixel    = pixel_q;
    assign PixelOut = pix_out_q;
    assign X        = x_q;
    assign Y        = y_q;
    assign Line     = line_q;
    assign Frame    = frame_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_pixel_sync.sv
// Directed-sequence bench for pixel_sync with randomized pixel data/valid and an
// event-list reference model built from the frame/line/pixel rules.
module tb_pixel_sync;

    logic       Clk = 1'b0;
    logic       nReset, VSync, HSync, PixelValid;
    logic [7:0] PixelData;
    logic       Pixel, Line, Frame, Overflow;
    logic [7:0] PixelOut, X, Y;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } pix_t;

    pix_t exp_pix[$];
    pix_t obs_pix[$];
    bit   exp_line[$];
    bit   obs_line[$];
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   bad_frame = 0;
    bit   model_on  = 1'b0;

    pixel_sync dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .VSync      (VSync),
        .HSync      (HSync),
        .PixelValid (PixelValid),
        .PixelData  (PixelData),
        .Pixel      (Pixel),
        .PixelOut   (PixelOut),
        .X          (X),
        .Y          (Y),
        .Line       (Line),
        .Frame      (Frame),
        .Overflow   (Overflow)
    );

    always #5 Clk = ~Clk;

    // Observed strobes are collected on the falling edge, away from the active edge
    always @(negedge Clk) begin
        if (Pixel) obs_pix.push_back({X, Y, PixelOut});
        if (Line)  obs_line.push_back(Frame);
        if (Frame && !Line) bad_frame++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        int np, nl;
        check({tag, "_pix_count"}, 32'(obs_pix.size()), 32'(exp_pix.size()));
        check({tag, "_line_count"}, 32'(obs_line.size()), 32'(exp_line.size()));
        np = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
        nl = (obs_line.size() < exp_line.size()) ? obs_line.size() : exp_line.size();
        for (int i = 0; i < np; i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(obs_pix[i]), 32'(exp_pix[i]));
        for (int i = 0; i < nl; i++)
            check($sformatf("%s_line%0d_frame", tag, i), 32'(obs_line[i]), 32'(exp_line[i]));
        obs_pix.delete();
        exp_pix.delete();
        obs_line.delete();
        exp_line.delete();
    endtask

    // mode 0: all valid, 1: random valid, 2: alternating starting with valid.
    // HSync rises with one idle cycle before any pixel; returns with HSync still high.
    task automatic drive_line(input int row, input int npix, input int mode);
        int   col;
        bit   v;
        pix_t p;
        col = 0;
        HSync = 1'b1;
        PixelValid = 1'b0;
        step();
        for (int k = 0; k < npix; k++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (k % 2 == 0);
            endcase
            PixelValid = v;
            PixelData  = 8'($urandom_range(0, 255));
            if (v) begin
                if (model_on && col < 256 && row < 256) begin
                    p.x = col[7:0];
                    p.y = row[7:0];
                    p.d = PixelData;
                    exp_pix.push_back(p);
                end
                col++;
            end
            step();
        end
        PixelValid = 1'b0;
    endtask

    // Every line of a frame yields one Line strobe; only the last carries Frame.
    task automatic run_frame(input int nlines, input int npix, input int mode, input bit abort);
        VSync = 1'b1;
        step(2);
        for (int r = 0; r < nlines; r++) begin
            drive_line(r, npix, mode);
            if (model_on) exp_line.push_back(r == nlines - 1);
            if (abort && r == nlines - 1) begin
                VSync = 1'b0;
                step();
            end
            HSync = 1'b0;
            step(2);
        end
        VSync = 1'b0;
        step(3);
    endtask

    initial begin
        nReset     = 1'b0;
        VSync      = 1'b1;
        HSync      = 1'b0;
        PixelValid = 1'b0;
        PixelData  = 8'h00;
        step(2);
        check("reset_outputs", 32'({Pixel, Line, Frame, Overflow, PixelOut, X, Y}), 32'd0);
        nReset = 1'b1;
        step(2);

        // Frame already running when reset released: must be ignored
        drive_line(0, 4, 0);
        HSync = 1'b0;
        step(2);
        drive_line(1, 4, 0);
        HSync = 1'b0;
        step(2);
        VSync = 1'b0;
        step(3);
        check_events("midframe_ignored");

        model_on = 1'b1;
        run_frame(3, 4, 0, 1'b0);
        check_events("frame3x4");
        check("ovf_clear", 32'(Overflow), 32'd0);

        run_frame(4, 5, 1, 1'b0);
        check_events("rand_frame");

        run_frame(2, 3, 1, 1'b1);
        check_events("vs_fall_in_line");

        run_frame(0, 0, 0, 1'b0);
        check_events("empty_frame");

        run_frame(1, 3, 2, 1'b0);
        check_events("valid_101");
        check("ovf_before_wide", 32'(Overflow), 32'd0);

        run_frame(1, 258, 0, 1'b0);
        check_events("wide_line");
        check("ovf_set", 32'(Overflow), 32'd1);

        run_frame(2, 3, 1, 1'b0);
        check_events("after_ovf");
        check("ovf_held", 32'(Overflow), 32'd1);

        // Reset in the middle of a line: strobes already emitted stay, nothing afterwards
        VSync = 1'b1;
        step(2);
        drive_line(0, 3, 0);
        exp_line.push_back(1'b0);
        HSync = 1'b0;
        step(2);
        drive_line(1, 3, 0);
        step();
        #2;
        nReset = 1'b0;
        #1;
        check("midline_reset_outputs", 32'({Pixel, Line, Frame, Overflow, PixelOut, X, Y}), 32'd0);
        model_on = 1'b0;
        #3;
        nReset = 1'b1;
        step(2);
        HSync = 1'b0;
        step(2);
        drive_line(2, 3, 0);
        HSync = 1'b0;
        step(2);
        VSync = 1'b0;
        step(3);
        check_events("reset_midline");
        check("ovf_cleared_by_reset", 32'(Overflow), 32'd0);

        model_on = 1'b1;
        run_frame(2, 2, 1, 1'b0);
        check_events("recovery");
        check("frame_without_line", 32'(bad_frame), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
